seq_divider4: RTL and testbench

Multi-cycle 4-bit unsigned restoring divider. It is the inverse-direction companion to the team's 4-bit adder datapath. Each iteration computes a trial subtraction through a ripple-carry adder in subtract mode (divisor inverted, carry-in 1). A start/busy/done handshake sequences the iterations. The block sits beside the adder in the small-arithmetic library and serves control logic that needs quotient and remainder without a combinational array divider.

---
 rtl/seq_divider4_pkg.sv | 22 ++
 rtl/ripple_carry_adder4.sv | 24 ++
 rtl/seq_divider4.sv | 139 +++++++++++++
 tb/tb_seq_divider4.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seq_divider4_pkg.sv
// Shared constants and types for the sequential 4-bit restoring divider.
//   state_e   : FSM encoding (IDLE, CALC, FIN, HOLD) in 2 bits
//   DIV_WIDTH : operand width
//   DIV_ITERS : number of CALC iterations, one per quotient bit
package seq_divider4_pkg;

  localparam int unsigned DIV_WIDTH = 4;
  localparam int unsigned DIV_ITERS = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,  // ready, no result yet
    StCalc = 2'd1,  // iterating
    StFin  = 2'd2,  // done pulse
    StHold = 2'd3   // ready, previous result still valid
  } state_e;

  // Reference result for a nonzero divisor is reached after exactly DIV_ITERS steps.
  function automatic logic [1:0] last_iter();
    return 2'(DIV_ITERS - 1);
  endfunction

endpackage

// File: rtl/ripple_carry_adder4.sv
// 4-bit ripple-carry adder from the small-arithmetic library.
//   p  : addend A
//   q  : addend B
//   c0 : carry-in
//   r  : {carry-out, sum[3:0]}
module ripple_carry_adder4 (
  input  logic [3:0] p,
  input  logic [3:0] q,
  input  logic       c0,
  output logic [4:0] r
);

  logic [4:0] c;

  assign c[0] = c0;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign r[i]   = p[i] ^ q[i] ^ c[i];
    assign c[i+1] = (p[i] & q[i]) | (c[i] & (p[i] ^ q[i]));
  end

  assign r[4] = c[4];

endmodule

// File: rtl/seq_divider4.sv
// Multi-cycle 4-bit unsigned restoring divider with start/busy/done handshake.
// One trial subtraction per cycle through ripple_carry_adder4 (subtract mode).
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset
//   start_i       : request a division (sampled in IDLE/HOLD only)
//   dividend_i    : unsigned dividend, captured with start
//   divisor_i     : unsigned divisor, captured with start
//   busy_o        : high while iterating
//   done_o        : one-cycle pulse when results become valid
//   quotient_o    : quotient, updated on FIN entry and held
//   remainder_o   : remainder, updated on FIN entry and held
//   div_by_zero_o : set with done when the captured divisor was 0
module seq_divider4
  import seq_divider4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [DIV_WIDTH-1:0] dividend_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DIV_WIDTH-1:0] quotient_o,
  output logic [DIV_WIDTH-1:0] remainder_o,
  output logic                 div_by_zero_o
);

  state_e               state_q;
  logic [1:0]           cnt_q;
  logic [DIV_WIDTH-1:0] d_q;
  logic [DIV_WIDTH-1:0] q_q;
  // R is conceptually 5 bits, but its MSB is always 0 after an iteration:
  // a kept trial clears it and a restored S only happens when S[4] was 0.
  logic [DIV_WIDTH-1:0] r_q;

  logic                 busy_q;
  logic                 done_q;
  logic [DIV_WIDTH-1:0] quotient_q;
  logic [DIV_WIDTH-1:0] remainder_q;
  logic                 dbz_q;

  logic [DIV_WIDTH:0]   s;
  logic [DIV_WIDTH-1:0] add_p;
  logic [DIV_WIDTH-1:0] add_q;
  logic [DIV_WIDTH:0]   add_r;
  logic                 trial_ok;
  logic [DIV_WIDTH-1:0] r_d;
  logic [DIV_WIDTH-1:0] q_d;

  // Trial subtraction S[3:0] - D as S[3:0] + ~D + 1.
  ripple_carry_adder4 u_adder (
    .p  (add_p),
    .q  (add_q),
    .c0 (1'b1),
    .r  (add_r)
  );

  always_comb begin
    s        = {r_q, q_q[DIV_WIDTH-1]};
    add_p    = s[DIV_WIDTH-1:0];
    add_q    = ~d_q;
    // S[4]=1 means S >= 16 > D, so the trial cannot go negative.
    trial_ok = s[DIV_WIDTH] | add_r[DIV_WIDTH];
    r_d      = trial_ok ? add_r[DIV_WIDTH-1:0] : s[DIV_WIDTH-1:0];
    q_d      = {q_q[DIV_WIDTH-2:0], trial_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          done_q <= 1'b0;
          if (start_i) begin
            d_q   <= divisor_i;
            q_q   <= dividend_i;
            r_q   <= '0;
            cnt_q <= '0;
            if (divisor_i == '0) begin
              // Divide by zero resolves immediately with a fixed response.
              state_q     <= StFin;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend_i;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= StCalc;
              busy_q  <= 1'b1;
            end
          end
        end

        StCalc: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == last_iter()) begin
            // Final iteration: publish this step's results directly.
            state_q     <= StFin;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= q_d;
            remainder_q <= r_d;
            dbz_q       <= 1'b0;
          end
        end

        StFin: begin
          done_q  <= 1'b0;
          state_q <= StHold;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider4.sv
module tb_seq_divider4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  seq_divider4 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy),
    .done_o        (done),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain integer division.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 4'd0) begin
      e.q   = 4'hF;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; start is sampled on the next posedge (edge 0).
  // Returns at the negedge after edge 0.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input bit push);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge after edge k0. Waits for done, checks latency,
  // busy length, results, then the following HOLD cycle.
  task automatic collect(input int k0, input int exp_lat);
    int   k;
    int   busy_n;
    bit   got;
    exp_t e;
    k      = k0;
    busy_n = 0;
    got    = 0;
    while (k <= 20) begin
      check("busy_done_excl", {7'd0, busy & done}, 8'd0);
      if (done) begin
        got = 1;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
      k++;
    end
    check("done_seen", {7'd0, got}, 8'd1);
    if (got) begin
      check("latency", 8'(k), 8'(exp_lat));
      check("busy_cycles", 8'(busy_n), 8'(exp_lat - k0));
      check("sb_nonempty", {7'd0, sb.size() != 0}, 8'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("quotient", {4'd0, quotient}, {4'd0, e.q});
        check("remainder", {4'd0, remainder}, {4'd0, e.r});
        check("div_by_zero", {7'd0, dbz}, {7'd0, e.dbz});
        if (e.b != 4'd0) begin
          check("invariant", 8'(int'(quotient) * int'(e.b) + int'(remainder)), {4'd0, e.a});
          check("rem_lt_div", {7'd0, remainder < e.b}, 8'd1);
        end
        @(negedge clk);
        check("hold_done", {7'd0, done}, 8'd0);
        check("hold_busy", {7'd0, busy}, 8'd0);
        check("hold_quot", {4'd0, quotient}, {4'd0, e.q});
        check("hold_rem", {4'd0, remainder}, {4'd0, e.r});
        check("hold_dbz", {7'd0, dbz}, {7'd0, e.dbz});
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_quot", {4'd0, quotient}, 8'd0);
    check("rst_rem", {4'd0, remainder}, 8'd0);
    check("rst_dbz", {7'd0, dbz}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and edge cases.
    issue(4'd13, 4'd4, 1);  collect(0, 4);
    issue(4'd15, 4'd1, 1);  collect(0, 4);
    issue(4'd7,  4'd9, 1);  collect(0, 4);
    issue(4'd15, 4'd15, 1); collect(0, 4);

    // Divide by zero, then recovery.
    issue(4'd9, 4'd0, 1);   collect(0, 0);
    issue(4'd6, 4'd3, 1);   collect(0, 4);

    // Start during CALC is ignored and not queued.
    issue(4'd13, 4'd4, 1);
    dividend = 4'd8;
    divisor  = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(1, 4);
    for (int i = 0; i < 8; i++) begin
      check("ign_no_done", {7'd0, done}, 8'd0);
      check("ign_quot", {4'd0, quotient}, 8'd3);
      check("ign_rem", {4'd0, remainder}, 8'd1);
      @(negedge clk);
    end
    check("ign_sb_empty", 8'(sb.size()), 8'd0);

    // Reset mid-operation.
    issue(4'd14, 4'd3, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_done", {7'd0, done}, 8'd0);
    check("mid_rst_quot", {4'd0, quotient}, 8'd0);
    check("mid_rst_rem", {4'd0, remainder}, 8'd0);
    check("mid_rst_dbz", {7'd0, dbz}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", {7'd0, done}, 8'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_done", {7'd0, done}, 8'd0);
    end
    issue(4'd14, 4'd3, 1);  collect(0, 4);

    // Exhaustive sweep, back-to-back from HOLD.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(4'(a), 4'(b), 1);
        collect(0, (b == 0) ? 0 : 4);
      end
    end
    check("final_sb_empty", 8'(sb.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
